spart_fifo: RTL and testbench
=============================

# spart_fifo

Parametrised successor to the SPART serial port. It joins the 8-bit I/O bus interface (iocs/iorw/ioaddr/databus) to a UART line with a programmable 16-bit baud divisor. It adds configurable frame format, TX and RX FIFOs, sticky error flags, two-stop-bit mode and internal loopback. It sits between the processor bus and the board serial pins.

## Interface
- FIFO_DEPTH, 4: entries per TX and RX FIFO; must be a power of 2, ≥2.
- DATA_BITS, 8: data bits per frame, 5..8.
- PARITY_EN, 0: 1 adds a parity bit after the data bits.
- PARITY_ODD, 0: with PARITY_EN=1, 1 selects odd parity and 0 selects even parity.
- DEFAULT_DIV, 16'h0145: divisor value after reset.
- clk  in  1  system clock; everything is in this single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- iocs  in  1  chip select.
- iorw  in  1  1 = read, 0 = write.
- ioaddr  in  2  register select: 00 data, 01 status/control, 10 divisor low, 11 divisor high.
- databus  inout  8  driven only while iocs=1 and iorw=1; Z otherwise.
- rda  out  1  RX FIFO not empty.
- tbr  out  1  TX FIFO not full.
- txd  out  1  serial output; idles at 1.
- rxd  in  1  serial input; asynchronous to clk.

## Operation
- **Reset values:**
  - txd=1, rda=0, tbr=1, databus=Z.
  - Both FIFOs empty; divisor=DEFAULT_DIV; control=0; error flags=0.
  - Both shifters idle.
  - Reset mid-frame aborts the frame and drives txd=1 immediately.
- **Bus access:** a transaction occurs on every clk edge where iocs=1.
  - Write 00: push databus[DATA_BITS-1:0] into the TX FIFO. If the FIFO is full, the word is dropped silently.
  - Read 00: databus shows the RX FIFO head, zero-extended, combinationally; the pop happens at the edge. Reading an empty FIFO returns 8'h00 with no pop.
  - Read 01: status = {2'b00, perr, ferr, ovr, tx_idle, tbr, rda}. This edge clears perr, ferr and ovr. If a set occurs in the same cycle, the set wins.
  - Write 01: control. bit0 = loopback (rxd path taken from internal txd; pin txd held 1). bit1 = two stop bits. Other bits are ignored.
  - Read/write 10/11: divisor[7:0] / divisor[15:8]. A write to 11 also reloads the baud counter.
- **Baud generator:** 16-bit down counter.
  - Emits a one-clk tick when it reaches 0, then reloads the divisor.
  - Tick period = divisor+1 clks. One bit time = 16 ticks.
- **TX FSM:** IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - Leaves IDLE on the first tick where the TX FIFO is non-empty; that tick pops the FIFO.
  - Data is sent LSB first.
  - STOP lasts 16 ticks, or 32 when control bit1 is set.
  - Back-to-back frames have no idle gap.
  - tx_idle = IDLE and TX FIFO empty.
- **RX FSM:** IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - rxd passes through a 2-flop synchroniser.
  - A falling edge in IDLE enters START. The line is re-sampled 8 ticks later; if it is 1, this is a false start and the FSM returns to IDLE.
  - Each subsequent bit is sampled 16 ticks after the previous sample.
  - Only the first stop bit is checked.
- **RX completion, at the stop sample:**
  - Stop bit = 0: set ferr and discard the word.
  - Parity mismatch: set perr and still push the word.
  - RX FIFO full: set ovr and drop the word. If a pop happens in the same cycle, the push succeeds.
- **Simultaneous push and pop** on either FIFO in one cycle is legal; the count is unchanged.

## Timing
- rda rises 1 clk after the stop-bit sample edge. It falls at the edge that pops the last entry.
- tbr updates at the push/pop edge, with no extra latency.
- The first txd falling edge occurs at the first tick at or after the push edge.
- Frame length = (1 + DATA_BITS + PARITY_EN + stop bits) × 16 × (divisor+1) clks.
- A divisor change mid-frame applies from the next reload. Frame integrity is not guaranteed in that case.

## Test plan
- **Reset:** pulse rst low mid-transmit → txd=1 asynchronously, rda=0, tbr=1, status read = 8'h06, divisor reads 8'h45/8'h01.
- **Basic round trip:** divisor=0, txd tied to rxd, write 8'hA5 → rda rises 160 ± 3 clks later; data read = 8'hA5; rda falls the next clk.
- **TX FIFO fill:** with FIFO_DEPTH=4, write 6 bytes 01..06 in consecutive cycles → tbr=0 after the 5th write; 06 is dropped; loopback delivers 01..05 in order.
- **Overrun:** send 5 frames with no reads → status = 8'h0B (ovr, tbr, rda set); bytes 1–4 are intact; a second status read shows ovr=0.
- **Framing error:** drive a frame for 8'h3C with stop bit 0 → ferr set; rda stays 0. A false start (a 4-tick low pulse) produces no flags.
- **Format:** DATA_BITS=7, PARITY_EN=1, PARITY_ODD=1, two stop bits. Send 7'h41 with even parity → perr set, read returns 8'h41. The TX frame measured on txd is 11 bit times.

Source files
------------

// File: rtl/spart_fifo.sv
// SPART serial port with TX/RX FIFOs, programmable frame format, sticky error flags
// and internal loopback behind the 8-bit iocs/iorw/ioaddr/databus I/O interface.

module spart_fifo_q #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // a push into a full queue still lands when the same cycle frees a slot
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module spart_fifo #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          DATA_BITS   = 8,
  parameter int          PARITY_EN   = 0,
  parameter int          PARITY_ODD  = 0,
  parameter logic [15:0] DEFAULT_DIV = 16'h0145
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       ODD      = (PARITY_ODD != 0);

  logic        bus_wr, bus_rd, tx_push, rx_pop, stat_rd;
  logic [1:0]  ctrl;
  logic [15:0] divisor, baud_cnt;
  logic        tick;

  logic [DATA_BITS-1:0] tx_head, rx_head;
  logic                 tx_empty, tx_full, rx_empty, rx_full;

  state_e               tx_state, tx_next;
  logic [4:0]           tx_ticks;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par, tx_pop, tx_line, tx_idle;
  logic                 tx_bit_end, tx_stop_end;

  state_e               rx_state, rx_next;
  logic                 rx_s1, rx_s2, rx_prev, rx_src;
  logic [3:0]           rx_ticks;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_pbit, rx_stop_smp;
  logic                 rx_done, rx_stop_ok, rx_bad_par, rx_push;
  logic                 perr, ferr, ovr;

  logic [7:0] status, rdata, rx_head_ext;

  assign bus_wr  = iocs && !iorw;
  assign bus_rd  = iocs && iorw;
  assign tx_push = bus_wr && (ioaddr == 2'b00);
  assign rx_pop  = bus_rd && (ioaddr == 2'b00) && !rx_empty;
  assign stat_rd = bus_rd && (ioaddr == 2'b01);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl    <= '0;
      divisor <= DEFAULT_DIV;
    end else if (bus_wr) begin
      case (ioaddr)
        2'b01:   ctrl           <= databus[1:0];
        2'b10:   divisor[7:0]   <= databus;
        2'b11:   divisor[15:8]  <= databus;
        default: ;
      endcase
    end
  end

  // a high-byte write restarts the count from the newly assembled divisor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          baud_cnt <= DEFAULT_DIV;
    else if (bus_wr && ioaddr == 2'b11) baud_cnt <= {databus, divisor[7:0]};
    else if (baud_cnt == '0)           baud_cnt <= divisor;
    else                               baud_cnt <= baud_cnt - 1'b1;
  end
  assign tick = (baud_cnt == '0);

  spart_fifo_q #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_q (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
    .wdata(databus[DATA_BITS-1:0]), .head(tx_head), .empty(tx_empty), .full(tx_full)
  );

  spart_fifo_q #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_q (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .wdata(rx_sh), .head(rx_head), .empty(rx_empty), .full(rx_full)
  );

  // ---------------- transmitter ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= S_IDLE;
    else      tx_state <= tx_next;
  end

  assign tx_bit_end  = tick && (tx_ticks == 5'd15);
  assign tx_stop_end = tick && (tx_ticks == (ctrl[1] ? 5'd31 : 5'd15));

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      S_IDLE: if (tick && !tx_empty) begin
        tx_next = S_START;
        tx_pop  = 1'b1;
      end
      S_START:  if (tx_bit_end) tx_next = S_DATA;
      S_DATA:   if (tx_bit_end && tx_bit == LAST_BIT)
                  tx_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tx_bit_end) tx_next = S_STOP;
      S_STOP: if (tx_stop_end) begin
        if (!tx_empty) begin
          tx_next = S_START;
          tx_pop  = 1'b1;
        end else begin
          tx_next = S_IDLE;
        end
      end
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ticks <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else if (tx_pop) begin
      tx_sh    <= tx_head;
      tx_par   <= (^tx_head) ^ ODD;
      tx_ticks <= '0;
      tx_bit   <= '0;
    end else if (tick) begin
      case (tx_state)
        S_START, S_PARITY: tx_ticks <= tx_bit_end ? '0 : tx_ticks + 1'b1;
        S_DATA: begin
          if (tx_bit_end) begin
            tx_ticks <= '0;
            tx_bit   <= tx_bit + 1'b1;
            tx_sh    <= tx_sh >> 1;
          end else begin
            tx_ticks <= tx_ticks + 1'b1;
          end
        end
        S_STOP:  tx_ticks <= tx_stop_end ? '0 : tx_ticks + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (tx_state)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_sh[0];
      S_PARITY: tx_line = tx_par;
      default:  tx_line = 1'b1;
    endcase
    txd     = ctrl[0] ? 1'b1 : tx_line;
    tx_idle = (tx_state == S_IDLE) && tx_empty;
  end

  // ---------------- receiver ----------------
  assign rx_src = ctrl[0] ? tx_line : rxd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_src;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= S_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next     = rx_state;
    rx_stop_smp = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_prev && !rx_s2) rx_next = S_START;
      S_START: if (tick && rx_ticks == 4'd7) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (tick && rx_ticks == 4'd15 && rx_bit == LAST_BIT)
                 rx_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick && rx_ticks == 4'd15) rx_next = S_STOP;
      S_STOP: if (tick && rx_ticks == 4'd15) begin
        rx_next     = S_IDLE;
        rx_stop_smp = 1'b1;
      end
      default: rx_next = S_IDLE;
    endcase
  end

  // rx_ticks wraps 15->0 on its own, giving one sample per 16 ticks after START
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ticks <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_pbit  <= 1'b0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_ticks <= '0;
          rx_bit   <= '0;
        end
        S_START: if (tick) rx_ticks <= (rx_ticks == 4'd7) ? '0 : rx_ticks + 1'b1;
        S_DATA: if (tick) begin
          rx_ticks <= rx_ticks + 1'b1;
          if (rx_ticks == 4'd15) begin
            rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
            rx_bit <= rx_bit + 1'b1;
          end
        end
        S_PARITY: if (tick) begin
          rx_ticks <= rx_ticks + 1'b1;
          if (rx_ticks == 4'd15) rx_pbit <= rx_s2;
        end
        S_STOP:  if (tick) rx_ticks <= rx_ticks + 1'b1;
        default: ;
      endcase
    end
  end

  // frame outcome is registered so the FIFO push lands one clk after the stop sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_done    <= 1'b0;
      rx_stop_ok <= 1'b0;
      rx_bad_par <= 1'b0;
    end else begin
      rx_done <= rx_stop_smp;
      if (rx_stop_smp) begin
        rx_stop_ok <= rx_s2;
        rx_bad_par <= (PARITY_EN != 0) && (rx_pbit != ((^rx_sh) ^ ODD));
      end
    end
  end

  assign rx_push = rx_done && rx_stop_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr <= 1'b0;
      ferr <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (rx_done && !rx_stop_ok)               ferr <= 1'b1;
      else if (stat_rd)                         ferr <= 1'b0;
      if (rx_push && rx_bad_par)                perr <= 1'b1;
      else if (stat_rd)                         perr <= 1'b0;
      if (rx_push && rx_full && !rx_pop)        ovr  <= 1'b1;
      else if (stat_rd)                         ovr  <= 1'b0;
    end
  end

  // ---------------- bus read side ----------------
  assign rda    = !rx_empty;
  assign tbr    = !tx_full;
  assign status = {2'b00, perr, ferr, ovr, tx_idle, tbr, rda};

  always_comb begin
    rx_head_ext = '0;
    rx_head_ext[DATA_BITS-1:0] = rx_head;
    case (ioaddr)
      2'b00:   rdata = rx_empty ? 8'h00 : rx_head_ext;
      2'b01:   rdata = status;
      2'b10:   rdata = divisor[7:0];
      default: rdata = divisor[15:8];
    endcase
  end

  assign databus = bus_rd ? rdata : 8'bz;
endmodule

// File: tb/tb_spart_fifo.sv
// Directed bench for spart_fifo: one default instance and one 7-bit odd-parity instance.

module tb_spart_fifo;
  logic       clk = 1'b0;
  logic       rst, iorw, iocs0, iocs1, tb_drive, tie;
  logic       rxd_drv0, rxd_drv1, rxd0;
  logic [1:0] ioaddr;
  logic [7:0] wval, d;
  wire  [7:0] db0, db1;
  logic       rda0, tbr0, txd0, rda1, tbr1, txd1, prev;
  int         total = 0, passed = 0, failed = 0, n;

  always #5 clk = ~clk;

  assign db0  = tb_drive ? wval : 8'bz;
  assign db1  = tb_drive ? wval : 8'bz;
  assign rxd0 = tie ? txd0 : rxd_drv0;

  spart_fifo u_dut (
    .clk(clk), .rst(rst), .iocs(iocs0), .iorw(iorw), .ioaddr(ioaddr),
    .databus(db0), .rda(rda0), .tbr(tbr0), .txd(txd0), .rxd(rxd0)
  );

  spart_fifo #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1)) u_fmt (
    .clk(clk), .rst(rst), .iocs(iocs1), .iorw(iorw), .ioaddr(ioaddr),
    .databus(db1), .rda(rda1), .tbr(tbr1), .txd(txd1), .rxd(rxd_drv1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a transaction happens on the posedge inside the task; returns 1ns after it
  task automatic bus_wr(input int inst, input logic [1:0] a, input logic [7:0] v);
    ioaddr = a; iorw = 1'b0; wval = v; tb_drive = 1'b1;
    iocs0 = (inst == 0); iocs1 = (inst == 1);
    @(posedge clk); #1;
    iocs0 = 1'b0; iocs1 = 1'b0; tb_drive = 1'b0;
  endtask

  task automatic bus_rd(input int inst, input logic [1:0] a, output logic [7:0] v);
    ioaddr = a; iorw = 1'b1; tb_drive = 1'b0;
    iocs0 = (inst == 0); iocs1 = (inst == 1);
    #1 v = (inst == 0) ? db0 : db1;
    @(posedge clk); #1;
    iocs0 = 1'b0; iocs1 = 1'b0; iorw = 1'b0;
  endtask

  task automatic wait_rda(input int inst, input int max, output int cnt);
    cnt = 0;
    while (cnt < max) begin
      @(posedge clk); #1;
      cnt++;
      if ((inst == 0 && rda0) || (inst == 1 && rda1)) break;
    end
  endtask

  task automatic rx_bit(input int inst, input logic v);
    if (inst == 0) rxd_drv0 = v; else rxd_drv1 = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic rx_frame(input int inst, input logic [7:0] data, input int nbits,
                          input int use_par, input logic par, input logic stop);
    @(negedge clk);
    rx_bit(inst, 1'b0);
    for (int i = 0; i < nbits; i++) rx_bit(inst, data[i]);
    if (use_par != 0) rx_bit(inst, par);
    rx_bit(inst, stop);
    if (inst == 0) rxd_drv0 = 1'b1; else rxd_drv1 = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; iorw = 1'b0; iocs0 = 1'b0; iocs1 = 1'b0; tb_drive = 1'b0;
    ioaddr = 2'b00; wval = 8'h00; tie = 1'b0; rxd_drv0 = 1'b1; rxd_drv1 = 1'b1;
    #22 rst = 1'b1;
    @(posedge clk); #1;

    // reset pulsed in the middle of a start bit
    bus_wr(0, 2'b10, 8'h00);
    bus_wr(0, 2'b11, 8'h00);
    bus_wr(0, 2'b00, 8'h5A);
    repeat (3) @(posedge clk); #1;
    check("tx_start_low", txd0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("rst_txd", txd0, 1'b1);
    check("rst_rda", rda0, 1'b0);
    check("rst_tbr", tbr0, 1'b1);
    #10 rst = 1'b1;
    @(posedge clk); #1;
    bus_rd(0, 2'b01, d); check("rst_status", d, 8'h06);
    bus_rd(0, 2'b10, d); check("rst_div_lo", d, 8'h45);
    bus_rd(0, 2'b11, d); check("rst_div_hi", d, 8'h01);

    // round trip through the pins, divisor 0 -> 160 clk frames
    bus_wr(0, 2'b10, 8'h00);
    bus_wr(0, 2'b11, 8'h00);
    tie = 1'b1;
    bus_wr(0, 2'b00, 8'hA5);
    wait_rda(0, 300, n);
    check("rt_latency_in_157_163", (n >= 157 && n <= 163), 1'b1);
    bus_rd(0, 2'b00, d); check("rt_data", d, 8'hA5);
    check("rt_rda_fall", rda0, 1'b0);
    bus_rd(0, 2'b00, d); check("rt_empty_read", d, 8'h00);
    tie = 1'b0;
    repeat (10) @(posedge clk); #1;

    // TX FIFO fill in loopback: one word moves straight to the shifter
    bus_wr(0, 2'b01, 8'h01);
    for (int i = 1; i <= 6; i++) begin
      bus_wr(0, 2'b00, 8'(i));
      if (i == 4) check("fill_tbr_after4", tbr0, 1'b1);
      if (i == 5) check("fill_tbr_after5", tbr0, 1'b0);
    end
    check("loop_pin_txd_high", txd0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      wait_rda(0, 400, n);
      check("fill_rda_seen", (n < 400), 1'b1);
      bus_rd(0, 2'b00, d);
      check("fill_data", d, 8'(k));
    end
    repeat (300) @(posedge clk); #1;
    check("fill_06_dropped", rda0, 1'b0);
    bus_rd(0, 2'b01, d); check("fill_status", d, 8'h06);

    // overrun: five back-to-back frames, no reads; fifth push lands ~797 clks in
    for (int i = 1; i <= 5; i++) bus_wr(0, 2'b00, 8'(i * 17));
    wait_rda(0, 400, n);
    check("ovr_first_rda", (n < 400), 1'b1);
    repeat (641) @(posedge clk); #1;
    bus_rd(0, 2'b01, d); check("ovr_status", d, 8'h0B);
    for (int i = 1; i <= 4; i++) begin
      bus_rd(0, 2'b00, d);
      check("ovr_data", d, 8'(i * 17));
    end
    bus_rd(0, 2'b01, d); check("ovr_cleared_status", d, 8'h06);

    // framing error and false start on the rxd pin
    bus_wr(0, 2'b01, 8'h00);
    rx_frame(0, 8'h3C, 8, 0, 1'b0, 1'b0);
    repeat (20) @(posedge clk); #1;
    check("ferr_rda", rda0, 1'b0);
    bus_rd(0, 2'b01, d); check("ferr_status", d, 8'h16);
    bus_rd(0, 2'b01, d); check("ferr_cleared", d, 8'h06);
    @(negedge clk);
    rxd_drv0 = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv0 = 1'b1;
    repeat (40) @(posedge clk); #1;
    bus_rd(0, 2'b01, d); check("false_start_status", d, 8'h06);
    check("false_start_rda", rda0, 1'b0);

    // 7 data bits, odd parity, two stop bits
    bus_wr(1, 2'b10, 8'h00);
    bus_wr(1, 2'b11, 8'h00);
    bus_wr(1, 2'b01, 8'h02);
    rx_frame(1, 8'h41, 7, 1, 1'b0, 1'b1);
    repeat (20) @(posedge clk); #1;
    check("fmt_rda", rda1, 1'b1);
    bus_rd(1, 2'b01, d); check("fmt_perr_status", d, 8'h27);
    bus_rd(1, 2'b00, d); check("fmt_data", d, 8'h41);

    // 7'h3F frames: only falling edges are start and bit6, so the next start marks frame end
    bus_wr(1, 2'b00, 8'h3F);
    bus_wr(1, 2'b00, 8'h3F);
    check("fmt_tx_start", txd1, 1'b0);
    n = 0;
    repeat (120) begin @(posedge clk); #1; n++; end
    prev = txd1;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (prev && !txd1) break;
      prev = txd1;
    end
    check("fmt_frame_len", 16'(n), 16'd176);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
